// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit operands consumed DIGIT bits per clock with a registered carry.
// Optional subtract mode and the sub port are enabled by defining SERADD_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, sum_q, sum_d;
  logic             carry_q, carry_d, inv_q, inv_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT:0]   dig;
  logic             dig_ovf;
  logic             sub_req;

`ifdef SERADD_SUB_EN
  assign sub_req = sub;
`else
  assign sub_req = 1'b0;
`endif

  assign dig = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // Same-sign operands producing a different-sign MSB equals carry-in XOR carry-out of the MSB.
  assign dig_ovf = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dig[DIGIT-1] != a_q[DIGIT-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    inv_d   = inv_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + ~cin; the final carry is inverted back into a borrow.
          a_d     = a;
          b_d     = sub_req ? ~b : b;
          carry_d = cin ^ sub_req;
          inv_d   = sub_req;
          psum_d  = '0;
          cnt_d   = CW'(NDIG);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        psum_d  = (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT)) | (psum_q >> DIGIT);
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig[DIGIT];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          sum_d   = psum_d;
          cout_d  = dig[DIGIT] ^ inv_q;
          ovf_d   = dig_ovf;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q != RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances (8x1, 8x4, 2x1) checked against hand-computed results.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st0, st1, st2, c0, c1, c2;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] a2, b2;
  logic       rdy0, rdy1, rdy2, dn0, dn1, dn2, co0, co1, co2, ov0, ov1, ov2;
  logic [7:0] s0, s1;
  logic [1:0] s2;
`ifdef SERADD_SUB_EN
  logic       sb0, sb1, sb2;
`endif

  int passed = 0;
  int total  = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8x1 (
    .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .cin(c0),
`ifdef SERADD_SUB_EN
    .sub(sb0),
`endif
    .ready(rdy0), .done(dn0), .sum(s0), .cout(co0), .ovf(ov0));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u8x4 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(c1),
`ifdef SERADD_SUB_EN
    .sub(sb1),
`endif
    .ready(rdy1), .done(dn1), .sum(s1), .cout(co1), .ovf(ov1));

  serial_adder #(.WIDTH(2), .DIGIT(1)) u2x1 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(c2),
`ifdef SERADD_SUB_EN
    .sub(sb2),
`endif
    .ready(rdy2), .done(dn2), .sum(s2), .cout(co2), .ovf(ov2));

  function automatic logic get_rdy(input int s);
    return (s == 0) ? rdy0 : (s == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic get_dn(input int s);
    return (s == 0) ? dn0 : (s == 1) ? dn1 : dn2;
  endfunction

  // Launch one operation on instance s; returns edges until done (-1 on timeout) and cycles with ready low.
  task automatic do_op(input int s, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic sv, output int lat, output int low);
    lat = 0;
    low = 0;
    case (s)
      0: begin a0 = av; b0 = bv; c0 = cv; st0 = 1'b1; end
      1: begin a1 = av; b1 = bv; c1 = cv; st1 = 1'b1; end
      default: begin a2 = av[1:0]; b2 = bv[1:0]; c2 = cv; st2 = 1'b1; end
    endcase
`ifdef SERADD_SUB_EN
    sb0 = sv; sb1 = sv; sb2 = sv;
`else
    if (sv) $display("note: sub requested without SERADD_SUB_EN");
`endif
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
      if (!get_rdy(s)) low++;
      if (get_dn(s)) return;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({rdy0, dn0, co0, ov0, s0} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) $display("FAIL reset_state got rdy/dn/co/ov/sum=%b want 1000_00000000", {rdy0, dn0, co0, ov0, s0});
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic;
    int lat, low;
    do_op(0, 8'd3, 8'd5, 1'b0, 1'b0, lat, low);
    total++; if (lat !== 9) $display("FAIL add_latency got %0d want 9", lat); else passed++;
    total++; if (low !== 8) $display("FAIL add_ready_low got %0d want 8", low); else passed++;
    total++; if ({co0, ov0, s0} !== {1'b0, 1'b0, 8'd8}) $display("FAIL add_3_5 got co/ov/sum=%b want 0_0_00001000", {co0, ov0, s0}); else passed++;
    @(posedge clk); #1;
    total++; if ({dn0, rdy0, s0} !== {1'b0, 1'b1, 8'd8}) $display("FAIL done_pulse got dn/rdy/sum=%b want 0_1_00001000", {dn0, rdy0, s0}); else passed++;
  endtask

  task automatic test_boundaries;
    int lat, low;
    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, lat, low);
    total++; if ({co0, ov0, s0} !== {1'b1, 1'b0, 8'h00}) $display("FAIL add_ff_01 got co/ov/sum=%b want 1_0_00000000", {co0, ov0, s0}); else passed++;
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, lat, low);
    total++; if ({co0, ov0, s0} !== {1'b0, 1'b1, 8'h80}) $display("FAIL add_7f_01 got co/ov/sum=%b want 0_1_10000000", {co0, ov0, s0}); else passed++;
    total++; if (lat !== 9) $display("FAIL boundary_latency got %0d want 9", lat); else passed++;
  endtask

  task automatic test_back_to_back;
    a1 = 8'hA5; b1 = 8'h5A; c1 = 1'b1; st1 = 1'b1;
    @(posedge clk); #1;
    total++; if (rdy1 !== 1'b0) $display("FAIL b2b_ready_fall got %b want 0", rdy1); else passed++;
    @(posedge clk); #1;
    total++; if ({dn1, rdy1} !== 2'b00) $display("FAIL b2b_run_ignore got dn/rdy=%b want 00", {dn1, rdy1}); else passed++;
    a1 = 8'h12; b1 = 8'h34; c1 = 1'b0;
    @(posedge clk); #1;
    total++; if ({dn1, co1, ov1, s1} !== {1'b1, 1'b1, 1'b0, 8'h00}) $display("FAIL b2b_first got dn/co/ov/sum=%b want 1_1_0_00000000", {dn1, co1, ov1, s1}); else passed++;
    @(posedge clk); #1;
    st1 = 1'b0;
    total++; if ({dn1, rdy1, s1} !== {1'b0, 1'b0, 8'h00}) $display("FAIL b2b_accept got dn/rdy/sum=%b want 0_0_00000000", {dn1, rdy1, s1}); else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if ({dn1, co1, ov1, s1} !== {1'b1, 1'b0, 1'b0, 8'h46}) $display("FAIL b2b_second got dn/co/ov/sum=%b want 1_0_0_01000110", {dn1, co1, ov1, s1}); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat, low;
    a0 = 8'h10; b0 = 8'h20; c0 = 1'b0; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if ({rdy0, dn0, co0, ov0, s0} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) $display("FAIL midreset_outputs got rdy/dn/co/ov/sum=%b want 1000_00000000", {rdy0, dn0, co0, ov0, s0}); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if ({dn0, rdy0} !== 2'b01) $display("FAIL midreset_hold%0d got dn/rdy=%b want 01", i, {dn0, rdy0}); else passed++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (dn0 !== 1'b0) $display("FAIL midreset_no_done got %b want 0", dn0); else passed++;
    do_op(0, 8'h10, 8'h20, 1'b0, 1'b0, lat, low);
    total++; if (lat !== 9) $display("FAIL midreset_next_latency got %0d want 9", lat); else passed++;
    total++; if ({co0, ov0, s0} !== {1'b0, 1'b0, 8'h30}) $display("FAIL midreset_next got co/ov/sum=%b want 0_0_00110000", {co0, ov0, s0}); else passed++;
  endtask

  task automatic test_exhaustive;
    int lat, low;
    logic [2:0] exp;
    logic [1:0] av, bv;
    logic       exp_ovf;
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          av = 2'(ia); bv = 2'(ib);
          exp = 3'(ia + ib + ic);
          exp_ovf = (av[1] == bv[1]) && (exp[1] != av[1]);
          do_op(2, {6'd0, av}, {6'd0, bv}, ic[0], 1'b0, lat, low);
          total++;
          if ({lat == 3, co2, s2, ov2} !== {1'b1, exp, exp_ovf})
            $display("FAIL exh_a%0d_b%0d_c%0d got lat=%0d co/sum=%b ovf=%b want lat=3 co/sum=%b ovf=%b", ia, ib, ic, lat, {co2, s2}, ov2, exp, exp_ovf);
          else passed++;
        end
  endtask

`ifdef SERADD_SUB_EN
  task automatic test_sub;
    int lat, low;
    do_op(0, 8'd5, 8'd7, 1'b0, 1'b1, lat, low);
    total++; if ({co0, ov0, s0} !== {1'b1, 1'b0, 8'hFE}) $display("FAIL sub_5_7 got co/ov/sum=%b want 1_0_11111110", {co0, ov0, s0}); else passed++;
    do_op(0, 8'h80, 8'h01, 1'b0, 1'b1, lat, low);
    total++; if ({co0, ov0, s0} !== {1'b0, 1'b1, 8'h7F}) $display("FAIL sub_80_01 got co/ov/sum=%b want 0_1_01111111", {co0, ov0, s0}); else passed++;
    do_op(0, 8'd3, 8'd5, 1'b0, 1'b0, lat, low);
    total++; if ({co0, ov0, s0} !== {1'b0, 1'b0, 8'd8}) $display("FAIL sub0_add got co/ov/sum=%b want 0_0_00001000", {co0, ov0, s0}); else passed++;
  endtask
`endif

  initial begin
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    c0 = 1'b0; c1 = 1'b0; c2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
`ifdef SERADD_SUB_EN
    sb0 = 1'b0; sb1 = 1'b0; sb2 = 1'b0;
`endif
    test_reset;
    test_add_basic;
    test_boundaries;
    test_back_to_back;
    test_reset_mid;
    test_exhaustive;
`ifdef SERADD_SUB_EN
    test_sub;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
